// File: rtl/list_packer_if.sv
// Stream-in / packet-out bundle for list_packer.
// The slave modport is the packer's view; master is the surrounding environment.
interface list_packer_if #(
    parameter int DW = 32,
    parameter int FS = 8
);
    logic [DW-1:0]         S_DATA;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    logic [FS-1:0][DW-1:0] OUT;
    logic                  o_valid;
    logic                  i_ready;

    modport slave (
        input  S_DATA, s_valid, s_last, i_ready,
        output s_ready, OUT, o_valid
    );

    modport master (
        output S_DATA, s_valid, s_last, i_ready,
        input  s_ready, OUT, o_valid
    );
endinterface

// File: rtl/list_packer.sv
// Packs a scalar element stream into FS-word packets (header + FS-1 payload), double-buffered.
// Define LIST_PACKER_TIMEOUT_EN to flush partial packets after TIMEOUT idle cycles.
module list_packer #(
    parameter int DW      = 32,
    parameter int FS      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic         CLK,
    input  logic         RESET_N,
    list_packer_if.slave bus
);
    localparam int TS = FS - 1;
    localparam int CW = $clog2(FS);

    typedef enum logic {EMPTY = 1'b0, PRESENT = 1'b1} state_t;

    state_t                state_q;
    logic [FS-1:0][DW-1:0] out_q;
    logic                  o_valid_q;
    logic                  phase_q;
    logic                  i_ready_q;
    logic                  ready_en_q;

    logic [DW-1:0]         fill_q [TS];
    logic [CW-1:0]         cnt_q;
    logic                  last_q;
    logic                  done_q;

    logic                  accept;
    logic                  ack;
    logic                  load;
    logic                  timeout_hit;
    logic [CW-1:0]         wr_idx;
    logic [FS-1:0][DW-1:0] pkt_d;

    // A complete fill only stalls input while the output slot is still occupied.
    assign bus.s_ready = ready_en_q & ~(done_q & (state_q == PRESENT));
    assign accept      = bus.s_valid & bus.s_ready;
    assign ack         = bus.i_ready & ~i_ready_q & o_valid_q;
    assign load        = done_q & ((state_q == EMPTY) | ack);
    assign wr_idx      = load ? '0 : cnt_q;

    assign bus.OUT     = out_q;
    assign bus.o_valid = o_valid_q;

    assign pkt_d[0] = DW'({cnt_q, last_q, ~phase_q});

    genvar gi;
    generate
        for (gi = 1; gi < FS; gi++) begin : g_payload
            assign pkt_d[gi] = (int'(cnt_q) >= gi) ? fill_q[gi-1] : '0;
        end
    endgenerate

    // Stale words beyond the fill count are masked at load, so storage needs no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            fill_q[wr_idx] <= bus.S_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ready_en_q <= 1'b0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (load) begin
                cnt_q  <= accept ? CW'(1) : '0;
                last_q <= accept & bus.s_last;
                done_q <= accept & (bus.s_last | (TS == 1));
            end else if (accept) begin
                cnt_q  <= cnt_q + CW'(1);
                last_q <= bus.s_last;
                done_q <= bus.s_last | (cnt_q == CW'(TS - 1));
            end else if (timeout_hit) begin
                done_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= EMPTY;
            out_q     <= (FS*DW)'(1);
            o_valid_q <= 1'b0;
            phase_q   <= 1'b1;
            i_ready_q <= 1'b0;
        end else begin
            i_ready_q <= bus.i_ready;
            case (state_q)
                EMPTY: begin
                    if (load) begin
                        out_q     <= pkt_d;
                        phase_q   <= ~phase_q;
                        o_valid_q <= 1'b1;
                        state_q   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        if (load) begin
                            out_q   <= pkt_d;
                            phase_q <= ~phase_q;
                        end else begin
                            o_valid_q <= 1'b0;
                            state_q   <= EMPTY;
                        end
                    end
                end
            endcase
        end
    end

`ifdef LIST_PACKER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] idle_q;
    logic          idle_run;

    assign idle_run    = (cnt_q != '0) & ~done_q & ~accept;
    assign timeout_hit = idle_run & (idle_q == IW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            idle_q <= '0;
        end else if (idle_run) begin
            idle_q <= idle_q + IW'(1);
        end else begin
            idle_q <= '0;
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

endmodule
